// File: rtl/graphite_cmd_tx.sv
// Command-stream transmitter: expands host drawing requests into 16-bit {opcode, payload} words on an AXI-stream master.
// Define GRAPHITE_CMD_SKIP_REDUNDANT_EN to drop SET_* words whose value matches the last one transmitted.
module graphite_cmd_tx #(
    parameter int unsigned CMD_STREAM_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [1:0]                  req_cmd_i,
    input  logic [11:0]                 req_x0_i,
    input  logic [11:0]                 req_y0_i,
    input  logic [11:0]                 req_x1_i,
    input  logic [11:0]                 req_y1_i,
    input  logic [11:0]                 req_color_i,
    output logic                        cmd_axis_tvalid_o,
    input  logic                        cmd_axis_tready_i,
    output logic [CMD_STREAM_WIDTH-1:0] cmd_axis_tdata_o,
    output logic                        busy_o
);

    localparam int unsigned FIELD_W   = 12;
    localparam int unsigned OPC_W     = 4;
    localparam int unsigned NUM_WORDS = 6;

    localparam logic [1:0] REQ_NOP       = 2'd0;
    localparam logic [1:0] REQ_CLEAR     = 2'd1;
    localparam logic [1:0] REQ_DRAW_LINE = 2'd2;
    localparam logic [1:0] REQ_SET_COLOR = 2'd3;

    localparam logic [OPC_W-1:0] OP_NOP       = 4'd0;
    localparam logic [OPC_W-1:0] OP_SET_X0    = 4'd1;
    localparam logic [OPC_W-1:0] OP_SET_Y0    = 4'd2;
    localparam logic [OPC_W-1:0] OP_SET_X1    = 4'd3;
    localparam logic [OPC_W-1:0] OP_SET_Y1    = 4'd4;
    localparam logic [OPC_W-1:0] OP_SET_COLOR = 4'd5;
    localparam logic [OPC_W-1:0] OP_CLEAR     = 4'd6;
    localparam logic [OPC_W-1:0] OP_DRAW_LINE = 4'd7;

    // Pending-word mask bit positions, in transmit order
    localparam int unsigned W_COLOR = 0;
    localparam int unsigned W_X0    = 1;
    localparam int unsigned W_Y0    = 2;
    localparam int unsigned W_X1    = 3;
    localparam int unsigned W_Y1    = 4;
    localparam int unsigned W_FINAL = 5;

    generate
        if (CMD_STREAM_WIDTH != 16) begin : g_width_check
            $error("graphite_cmd_tx: CMD_STREAM_WIDTH must be 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [NUM_WORDS-1:0]        mask_q, mask_d, mask_init;
    logic [CMD_STREAM_WIDTH-1:0] tdata_q, tdata_d;
    logic                        tvalid_q, ready_q, busy_q;
    logic                        accept;
    logic                        handshake;

    logic [1:0]         cmd_q;
    logic [FIELD_W-1:0] color_q, x0_q, y0_q, x1_q, y1_q;

    // Full word list for a request kind, before any redundancy filtering
    function automatic logic [NUM_WORDS-1:0] base_mask(input logic [1:0] cmd);
        base_mask = '0;
        case (cmd)
            REQ_NOP:       base_mask = 6'b100000;
            REQ_CLEAR:     base_mask = 6'b100001;
            REQ_DRAW_LINE: base_mask = 6'b111111;
            REQ_SET_COLOR: base_mask = 6'b000001;
            default:       base_mask = '0;
        endcase
    endfunction

    // Word for the lowest pending mask bit
    function automatic logic [CMD_STREAM_WIDTH-1:0] make_word(
        input logic [NUM_WORDS-1:0] mask,
        input logic [1:0]           cmd,
        input logic [FIELD_W-1:0]   color,
        input logic [FIELD_W-1:0]   x0,
        input logic [FIELD_W-1:0]   y0,
        input logic [FIELD_W-1:0]   x1,
        input logic [FIELD_W-1:0]   y1
    );
        logic [OPC_W-1:0] final_op;
        make_word = '0;
        final_op  = OP_NOP;
        if (cmd == REQ_CLEAR) begin
            final_op = OP_CLEAR;
        end else if (cmd == REQ_DRAW_LINE) begin
            final_op = OP_DRAW_LINE;
        end
        if (mask[W_COLOR]) begin
            make_word = {OP_SET_COLOR, color};
        end else if (mask[W_X0]) begin
            make_word = {OP_SET_X0, x0};
        end else if (mask[W_Y0]) begin
            make_word = {OP_SET_Y0, y0};
        end else if (mask[W_X1]) begin
            make_word = {OP_SET_X1, x1};
        end else if (mask[W_Y1]) begin
            make_word = {OP_SET_Y1, y1};
        end else if (mask[W_FINAL]) begin
            make_word = {final_op, FIELD_W'(0)};
        end
    endfunction

    assign handshake = (state_q == ST_SEND) && cmd_axis_tready_i;

`ifdef GRAPHITE_CMD_SKIP_REDUNDANT_EN
    logic [FIELD_W-1:0] sh_color_q, sh_x0_q, sh_y0_q, sh_x1_q, sh_y1_q;
    logic [4:0]         sh_valid_q;
    logic [4:0]         sh_match;
    logic [4:0]         cur_onehot;

    always_comb begin
        sh_match          = '0;
        sh_match[W_COLOR] = sh_valid_q[W_COLOR] && (sh_color_q == req_color_i);
        sh_match[W_X0]    = sh_valid_q[W_X0] && (sh_x0_q == req_x0_i);
        sh_match[W_Y0]    = sh_valid_q[W_Y0] && (sh_y0_q == req_y0_i);
        sh_match[W_X1]    = sh_valid_q[W_X1] && (sh_x1_q == req_x1_i);
        sh_match[W_Y1]    = sh_valid_q[W_Y1] && (sh_y1_q == req_y1_i);
    end

    assign mask_init  = base_mask(req_cmd_i) & ~{1'b0, sh_match};
    assign cur_onehot = 5'(mask_q & ~(mask_q - 6'(1)));

    // Shadows track the last value actually handed to the rasterizer
    always_ff @(posedge clk) begin
        if (reset_i) begin
            sh_valid_q <= '0;
            sh_color_q <= '0;
            sh_x0_q    <= '0;
            sh_y0_q    <= '0;
            sh_x1_q    <= '0;
            sh_y1_q    <= '0;
        end else if (handshake) begin
            if (cur_onehot[W_COLOR]) begin
                sh_color_q          <= color_q;
                sh_valid_q[W_COLOR] <= 1'b1;
            end
            if (cur_onehot[W_X0]) begin
                sh_x0_q          <= x0_q;
                sh_valid_q[W_X0] <= 1'b1;
            end
            if (cur_onehot[W_Y0]) begin
                sh_y0_q          <= y0_q;
                sh_valid_q[W_Y0] <= 1'b1;
            end
            if (cur_onehot[W_X1]) begin
                sh_x1_q          <= x1_q;
                sh_valid_q[W_X1] <= 1'b1;
            end
            if (cur_onehot[W_Y1]) begin
                sh_y1_q          <= y1_q;
                sh_valid_q[W_Y1] <= 1'b1;
            end
        end
    end
`else
    assign mask_init = base_mask(req_cmd_i);
`endif

    // Next-state, pending mask and outgoing word
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        tdata_d = tdata_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    accept = 1'b1;
                    mask_d = mask_init;
                    if (mask_init != '0) begin
                        state_d = ST_SEND;
                        tdata_d = make_word(mask_init, req_cmd_i, req_color_i,
                                            req_x0_i, req_y0_i, req_x1_i, req_y1_i);
                    end else begin
                        // Everything filtered out: one busy cycle, no words
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_SEND: begin
                if (cmd_axis_tready_i) begin
                    mask_d  = mask_q & (mask_q - 6'(1));
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (mask_q != '0) begin
                    state_d = ST_SEND;
                    tdata_d = make_word(mask_q, cmd_q, color_q, x0_q, y0_q, x1_q, y1_q);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            tdata_q  <= tdata_d;
            tvalid_q <= (state_d == ST_SEND);
            ready_q  <= (state_d == ST_IDLE);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    // Request fields captured at acceptance
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cmd_q   <= REQ_NOP;
            color_q <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
        end else if (accept) begin
            cmd_q   <= req_cmd_i;
            color_q <= req_color_i;
            x0_q    <= req_x0_i;
            y0_q    <= req_y0_i;
            x1_q    <= req_x1_i;
            y1_q    <= req_y1_i;
        end
    end

    assign req_ready_o       = ready_q;
    assign cmd_axis_tvalid_o = tvalid_q;
    assign cmd_axis_tdata_o  = tdata_q;
    assign busy_o            = busy_q;

endmodule

// File: tb/tb_graphite_cmd_tx.sv
// Scoreboard bench for graphite_cmd_tx: expected words queued at request time, compared at each handshake.
module tb_graphite_cmd_tx;

    localparam logic [1:0] C_NOP   = 2'd0;
    localparam logic [1:0] C_CLEAR = 2'd1;
    localparam logic [1:0] C_DRAW  = 2'd2;
    localparam logic [1:0] C_COLOR = 2'd3;
`ifdef GRAPHITE_CMD_SKIP_REDUNDANT_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_cmd_i = 2'd0;
    logic [11:0] req_x0_i = '0, req_y0_i = '0, req_x1_i = '0, req_y1_i = '0, req_color_i = '0;
    logic        cmd_axis_tvalid_o;
    logic        cmd_axis_tready_i = 1'b1;
    logic [15:0] cmd_axis_tdata_o;
    logic        busy_o;

    always #5 clk = ~clk;

    graphite_cmd_tx #(.CMD_STREAM_WIDTH(16)) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_cmd_i         (req_cmd_i),
        .req_x0_i          (req_x0_i),
        .req_y0_i          (req_y0_i),
        .req_x1_i          (req_x1_i),
        .req_y1_i          (req_y1_i),
        .req_color_i       (req_color_i),
        .cmd_axis_tvalid_o (cmd_axis_tvalid_o),
        .cmd_axis_tready_i (cmd_axis_tready_i),
        .cmd_axis_tdata_o  (cmd_axis_tdata_o),
        .busy_o            (busy_o)
    );

    int          errors = 0;
    int          checks = 0;
    int          words_seen = 0;
    logic [15:0] exp_q[$];
    logic        hold_pend = 1'b0, stall_pend = 1'b0;
    logic [15:0] hold_word = '0, stall_word = '0;
    logic [4:0]  m_valid = '0;
    logic [11:0] m_val[5];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: queue one SET_* word unless the redundancy filter would drop it
    task automatic push_set(input int idx, input logic [3:0] opc, input logic [11:0] val);
        if (SKIP_EN && m_valid[idx] && m_val[idx] == val) return;
        m_valid[idx] = 1'b1;
        m_val[idx]   = val;
        exp_q.push_back({opc, val});
    endtask

    task automatic push_req(input logic [1:0] cmd, input logic [11:0] x0, y0, x1, y1, col);
        if (cmd != C_NOP) push_set(0, 4'h5, col);
        if (cmd == C_DRAW) begin
            push_set(1, 4'h1, x0);
            push_set(2, 4'h2, y0);
            push_set(3, 4'h3, x1);
            push_set(4, 4'h4, y1);
        end
        case (cmd)
            C_NOP:   exp_q.push_back(16'h0000);
            C_CLEAR: exp_q.push_back(16'h6000);
            C_DRAW:  exp_q.push_back(16'h7000);
            default: ;
        endcase
    endtask

    task automatic scramble();
        req_cmd_i   = 2'($urandom_range(0, 3));
        req_x0_i    = 12'($urandom);
        req_y0_i    = 12'($urandom);
        req_x1_i    = 12'($urandom);
        req_y1_i    = 12'($urandom);
        req_color_i = 12'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic send_req(input logic [1:0] cmd, input logic [11:0] x0, y0, x1, y1, col);
        int n = 0;
        while (!req_ready_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check_eq("ready_timeout", 32'(req_ready_o), 32'd1);
        req_cmd_i = cmd; req_x0_i = x0; req_y0_i = y0; req_x1_i = x1; req_y1_i = y1; req_color_i = col;
        req_valid_i = 1'b1;
        push_req(cmd, x0, y0, x1, y1, col);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        scramble();
    endtask

    // Wait for ready, jiggling request inputs (and optionally tready) while busy
    task automatic wait_idle(input bit rnd_ready);
        bit done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            if (req_ready_o) begin
                done = 1'b1;
            end else begin
                check_eq("busy_while_not_ready", 32'(busy_o), 32'd1);
                req_valid_i = 1'($urandom_range(0, 1));
                scramble();
                if (rnd_ready) cmd_axis_tready_i = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        req_valid_i       = 1'b0;
        cmd_axis_tready_i = 1'b1;
        if (!done) check_eq("idle_timeout", 32'(req_ready_o), 32'd1);
        check_eq("words_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_req(input string tag, input logic [1:0] cmd,
                           input logic [11:0] x0, y0, x1, y1, col, input int exp_words);
        int base = words_seen;
        send_req(cmd, x0, y0, x1, y1, col);
        wait_idle(1'b0);
        check_eq(tag, 32'(words_seen - base), 32'(exp_words));
    endtask

    // Handshake monitor plus stall and HOLD stability checks
    always @(negedge clk) begin
        if (reset_i) begin
            hold_pend  = 1'b0;
            stall_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check_eq("hold_tvalid", 32'(cmd_axis_tvalid_o), 32'd0);
                check_eq("hold_tdata", 32'(cmd_axis_tdata_o), 32'(hold_word));
                hold_pend = 1'b0;
            end
            if (stall_pend && cmd_axis_tvalid_o)
                check_eq("stall_tdata", 32'(cmd_axis_tdata_o), 32'(stall_word));
            stall_pend = 1'b0;
            if (cmd_axis_tvalid_o && cmd_axis_tready_i) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    check_eq("extra_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    hold_word = exp_q.pop_front();
                    check_eq("word", 32'(cmd_axis_tdata_o), 32'(hold_word));
                    hold_pend = 1'b1;
                end
            end else if (cmd_axis_tvalid_o) begin
                stall_pend = 1'b1;
                stall_word = cmd_axis_tdata_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tvalid", 32'(cmd_axis_tvalid_o), 32'd0);
        check_eq("rst_tdata", 32'(cmd_axis_tdata_o), 32'h0000);
        check_eq("rst_ready", 32'(req_ready_o), 32'd1);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        reset_i = 1'b0;
        @(posedge clk); #1;

        // DRAW_LINE with tready high: 1,0 tvalid pattern, ready back 13 cycles after acceptance
        base = words_seen;
        send_req(C_DRAW, 12'h003, 12'h005, 12'h064, 12'hFFE, 12'h0F0);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c <= 12) check_eq("draw_tvalid", 32'(cmd_axis_tvalid_o), 32'(c % 2));
            check_eq("draw_ready", 32'(req_ready_o), 32'(c == 13));
        end
        @(posedge clk); #1;
        check_eq("draw_words", 32'(words_seen - base), 32'd6);
        check_eq("draw_left", 32'(exp_q.size()), 32'd0);

        // Repeat and single-field change
        run_req("draw_repeat", C_DRAW, 12'h003, 12'h005, 12'h064, 12'hFFE, 12'h0F0, SKIP_EN ? 1 : 6);
        run_req("draw_y1", C_DRAW, 12'h003, 12'h005, 12'h064, 12'h007, 12'h0F0, SKIP_EN ? 2 : 6);

        // SET_COLOR matching the last colour sent
        base = words_seen;
        send_req(C_COLOR, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0F0);
`ifdef GRAPHITE_CMD_SKIP_REDUNDANT_EN
        @(negedge clk);
        check_eq("skip_busy", 32'(busy_o), 32'd1);
        check_eq("skip_tvalid", 32'(cmd_axis_tvalid_o), 32'd0);
        @(negedge clk);
        check_eq("skip_ready", 32'(req_ready_o), 32'd1);
        check_eq("skip_tvalid2", 32'(cmd_axis_tvalid_o), 32'd0);
        @(posedge clk); #1;
`else
        wait_idle(1'b0);
`endif
        check_eq("color_words", 32'(words_seen - base), SKIP_EN ? 32'd0 : 32'd1);

        // CLEAR with tready stalled for 5 cycles
        base = words_seen;
        cmd_axis_tready_i = 1'b0;
        send_req(C_CLEAR, 12'h0, 12'h0, 12'h0, 12'h0, 12'hABC);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(cmd_axis_tvalid_o), 32'd1);
            check_eq("stall_word", 32'(cmd_axis_tdata_o), 32'h5ABC);
        end
        @(posedge clk); #1;
        cmd_axis_tready_i = 1'b1;
        wait_idle(1'b0);
        check_eq("clear_words", 32'(words_seen - base), 32'd2);

        // Reset while the third DRAW_LINE word sits in SEND
        base = words_seen;
        send_req(C_DRAW, 12'h007, 12'h009, 12'h020, 12'h030, 12'h123);
        n = 0;
        while (!(cmd_axis_tvalid_o && words_seen == base + 2) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rst_mid_tdata_pre", 32'(cmd_axis_tdata_o), 32'h2009);
        reset_i = 1'b1;
        cmd_axis_tready_i = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_tvalid", 32'(cmd_axis_tvalid_o), 32'd0);
        check_eq("rst_mid_tdata", 32'(cmd_axis_tdata_o), 32'h0000);
        check_eq("rst_mid_ready", 32'(req_ready_o), 32'd1);
        check_eq("rst_mid_busy", 32'(busy_o), 32'd0);
        exp_q.delete();
        m_valid = '0;
        reset_i = 1'b0;
        cmd_axis_tready_i = 1'b1;
        @(posedge clk); #1;
        run_req("clear_after_rst", C_CLEAR, 12'h0, 12'h0, 12'h0, 12'h0, 12'h123, 2);

        // Random requests with random tready and input noise while busy
        for (int i = 0; i < 12; i++) begin
            send_req(2'($urandom_range(0, 3)), 12'($urandom_range(0, 2)), 12'($urandom_range(0, 2)),
                     12'($urandom_range(0, 2)), 12'($urandom_range(0, 2)), 12'($urandom_range(0, 2)));
            wait_idle(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
